// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential, PC-relative, register-indirect and return
// redirects, with a circular return-address stack and trap/misalignment handling.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            stall,
  input  logic            trap_en,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            ras_push,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign,
  output logic            ras_underflow,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_REL = 2'b01,
    SEL_IND = 2'b10,
    SEL_RET = 2'b11
  } pc_sel_e;

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   top_ptr, top_ptr_next;
  logic [CW-1:0]   count, count_next;
  logic [XLEN-1:0] pc_next, target;
  logic            misalign_next, underflow_next;
  logic            do_push;
  logic            ras_we;
  logic [PW-1:0]   ras_waddr;

  assign pc_plus4  = pc_out + XLEN'(4);
  assign ras_empty = (count == '0);
  assign ras_full  = (count == CW'(RAS_DEPTH));

  // NOTE: every signal gets a default before any branch so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    pc_next        = pc_out;
    top_ptr_next   = top_ptr;
    count_next     = count;
    misalign_next  = 1'b0;
    underflow_next = 1'b0;
    do_push        = 1'b0;
    ras_we         = 1'b0;
    ras_waddr      = top_ptr + 1'b1;
    target         = '0;

    if (trap_en) begin
      pc_next = TRAP_VECTOR;
    end else if (!stall) begin
      unique case (pc_sel_e'(pc_sel))
        SEL_SEQ: begin
          pc_next = pc_plus4;
          do_push = ras_push;
        end
        SEL_REL, SEL_IND: begin
          target = (pc_sel == SEL_REL) ? (pc_out + imm) : ((rs1 + imm) & ~XLEN'(1));
          if (target[1:0] != 2'b00) begin
            pc_next       = TRAP_VECTOR;
            misalign_next = 1'b1;
          end else begin
            pc_next = target;
            do_push = ras_push;
          end
        end
        SEL_RET: begin
          if (count != '0) begin
            pc_next = ras_mem[top_ptr];
            if (ras_push) begin
              // Call-and-return in one cycle: the popped slot takes the new link.
              ras_we    = 1'b1;
              ras_waddr = top_ptr;
            end else begin
              top_ptr_next = top_ptr - 1'b1;
              count_next   = count - 1'b1;
            end
          end else begin
            pc_next        = pc_plus4;
            underflow_next = 1'b1;
            do_push        = ras_push;
          end
        end
        default: ;
      endcase

      // Pushing when full lands on the oldest slot because the pointer wraps.
      if (do_push) begin
        ras_we       = 1'b1;
        top_ptr_next = top_ptr + 1'b1;
        if (!ras_full) count_next = count + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (areset) begin
      pc_out        <= RESET_VECTOR;
      top_ptr       <= '0;
      count         <= '0;
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_out        <= pc_next;
      top_ptr       <= top_ptr_next;
      count         <= count_next;
      misalign      <= misalign_next;
      ras_underflow <= underflow_next;
    end
  end

  // NOTE: the stack storage is deliberately not reset; count gates every read,
  // so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!areset && ras_we) ras_mem[ras_waddr] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the PC and return stack.
module tb_pc_sequencer;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h100;

  logic            clk = 1'b0;
  logic            areset, stall, trap_en, ras_push;
  logic [1:0]      pc_sel;
  logic [XLEN-1:0] imm, rs1;
  logic [XLEN-1:0] pc_out, pc_plus4;
  logic            misalign, ras_underflow, ras_empty, ras_full;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_mis, m_und;

  pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .areset(areset), .stall(stall), .trap_en(trap_en), .pc_sel(pc_sel),
    .imm(imm), .rs1(rs1), .ras_push(ras_push), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .misalign(misalign), .ras_underflow(ras_underflow), .ras_empty(ras_empty),
    .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  // Reference: a PC value plus a bounded LIFO holding the newest DEPTH return links.
  task automatic model_step(input logic rst, input logic trp, input logic stl,
                            input logic [1:0] sel, input logic [31:0] im,
                            input logic [31:0] r1, input logic psh);
    logic [31:0] ret;
    logic [31:0] tgt;
    logic        push_ok;
    ret     = m_pc + 32'd4;
    push_ok = psh;
    m_mis   = 1'b0;
    m_und   = 1'b0;
    if (rst) begin
      m_pc = RV;
      m_ras.delete();
      return;
    end
    if (trp) begin
      m_pc = TV;
      return;
    end
    if (stl) return;
    case (sel)
      2'd0: m_pc = ret;
      2'd1, 2'd2: begin
        tgt = (sel == 2'd1) ? m_pc + im : ((r1 + im) & 32'hFFFF_FFFE);
        if (tgt[1:0] != 2'b00) begin
          m_pc    = TV;
          m_mis   = 1'b1;
          push_ok = 1'b0;
        end else begin
          m_pc = tgt;
        end
      end
      default: begin
        if (m_ras.size() > 0) begin
          m_pc = m_ras.pop_back();
        end else begin
          m_pc  = ret;
          m_und = 1'b1;
        end
      end
    endcase
    if (push_ok) begin
      m_ras.push_back(ret);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end
  endtask

  task automatic drive(input logic rst, input logic trp, input logic stl,
                       input logic [1:0] sel, input logic [31:0] im,
                       input logic [31:0] r1, input logic psh);
    areset   = rst;
    trap_en  = trp;
    stall    = stl;
    pc_sel   = sel;
    imm      = im;
    rs1      = r1;
    ras_push = psh;
    model_step(rst, trp, stl, sel, im, r1, psh);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 2'd3, 32'h13, 32'h77, 1'b1);
    n_checks++;
    if ({pc_out, misalign, ras_underflow, ras_empty, ras_full} !== {RV, 4'b0010}) begin
      n_fail++;
      $display("FAIL reset: pc=%h mis=%b und=%b empty=%b full=%b, expected pc=%h 0 0 1 0",
               pc_out, misalign, ras_underflow, ras_empty, ras_full, RV);
    end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (pc_out !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4) || ras_empty !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_%0d: pc=%h plus4=%h empty=%b, expected pc=%h plus4=%h empty=1",
                 i, pc_out, pc_plus4, ras_empty, 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_relative();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd1, -32'sd8, 32'h0, 1'b0);
    n_checks++;
    if (pc_out !== 32'h0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_back: pc=%h mis=%b, expected pc=0 mis=0", pc_out, misalign);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd1, 32'h6, 32'h0, 1'b1);
    n_checks++;
    if (pc_out !== TV || misalign !== 1'b1 || ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rel_misalign: pc=%h mis=%b empty=%b, expected pc=%h mis=1 empty=1",
               pc_out, misalign, ras_empty, TV);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (pc_out !== TV + 32'd4 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_pulse: pc=%h mis=%b, expected pc=%h mis=0",
               pc_out, misalign, TV + 32'd4);
    end
  endtask

  task automatic test_indirect();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd1, 32'h10, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h201, 1'b1);
    n_checks++;
    if (pc_out !== 32'h200 || ras_empty !== 1'b0 || misalign !== 1'b0) begin
      n_fail++;
      $display("FAIL indirect_call: pc=%h empty=%b mis=%b, expected pc=200 empty=0 mis=0",
               pc_out, ras_empty, misalign);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (pc_out !== 32'h14 || ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL indirect_ret: pc=%h empty=%b und=%b, expected pc=14 empty=1 und=0",
               pc_out, ras_empty, ras_underflow);
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h44, 32'h34, 32'h24, 32'h14};
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 2'd1, 32'h10, 32'h0, 1'b1);
    n_checks++;
    if (pc_out !== 32'h50 || ras_full !== 1'b1) begin
      n_fail++;
      $display("FAIL ras_fill: pc=%h full=%b, expected pc=50 full=1", pc_out, ras_full);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 1'b0);
      n_checks++;
      if (pc_out !== exp_ret[i] || ras_underflow !== 1'b0 || ras_full !== 1'b0) begin
        n_fail++;
        $display("FAIL ras_ret_%0d: pc=%h und=%b full=%b, expected pc=%h und=0 full=0",
                 i, pc_out, ras_underflow, ras_full, exp_ret[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (pc_out !== 32'h18 || ras_underflow !== 1'b1 || ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ras_underflow: pc=%h und=%b empty=%b, expected pc=18 und=1 empty=1",
               pc_out, ras_underflow, ras_empty);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 32'h40, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 32'h40, 32'h0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 32'h40, 32'h0, 1'b1);
    n_checks++;
    if (pc_out !== 32'h4 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: pc=%h empty=%b full=%b, expected pc=4 empty=0 full=0",
               pc_out, ras_empty, ras_full);
    end
    drive(1'b0, 1'b1, 1'b1, 2'd3, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (pc_out !== TV || ras_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_trap: pc=%h empty=%b, expected pc=%h empty=0", pc_out, ras_empty, TV);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (pc_out !== 32'h4 || ras_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_ret: pc=%h empty=%b, expected pc=4 empty=1", pc_out, ras_empty);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 2'd1, 32'h20, 32'h0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 2'd3, 32'h0, 32'h0, 1'b1);
    n_checks++;
    if (pc_out !== RV || ras_empty !== 1'b1 || misalign !== 1'b0 || ras_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: pc=%h empty=%b mis=%b und=%b, expected pc=%h empty=1 0 0",
               pc_out, ras_empty, misalign, ras_underflow, RV);
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    n_checks++;
    if (pc_out !== RV + 32'd4) begin
      n_fail++;
      $display("FAIL post_reset: pc=%h, expected %h", pc_out, RV + 32'd4);
    end
  endtask

  task automatic test_random();
    logic [31:0] im;
    for (int i = 0; i < 400; i++) begin
      im = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 255)) << 2;
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 4) == 0,
            2'($urandom_range(0, 3)), im, $urandom(), $urandom_range(0, 1) == 1);
      n_checks++;
      if ({pc_out, pc_plus4, misalign, ras_underflow, ras_empty, ras_full} !==
          {m_pc, m_pc + 32'd4, m_mis, m_und, m_ras.size() == 0, m_ras.size() == DEPTH}) begin
        n_fail++;
        $display("FAIL random_%0d: pc=%h plus4=%h mis=%b und=%b empty=%b full=%b, expected pc=%h mis=%b und=%b depth=%0d",
                 i, pc_out, pc_plus4, misalign, ras_underflow, ras_empty, ras_full,
                 m_pc, m_mis, m_und, m_ras.size());
      end
    end
  endtask

  initial begin
    areset = 1'b1; stall = 1'b0; trap_en = 1'b0; pc_sel = 2'd0;
    imm = '0; rs1 = '0; ras_push = 1'b0;
    m_pc = RV; m_mis = 1'b0; m_und = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_relative();
    test_indirect();
    test_ras_overflow();
    test_stall();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
